chan_mux_rr: RTL

- Parametrised N:1 data-path multiplexer with a registered output, and the next generation of the team's 4:1 select mux.
- Adds per-channel valid/ready handshakes and two selection modes:
  - fixed: the channel is chosen by the sel port;
  - round-robin: hardware arbitration across all requesting channels.
- Sits between several producer channels and one consumer, for example test-pattern sources feeding a single checker port.

---
 rtl/chan_mux_rr.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: parametrised N:1 channel multiplexer with a single-entry
// registered output stage and per-channel valid/ready handshakes.
//
// Selection modes:
//   mode = 0 : fixed select. The channel named by sel is granted when it is
//              valid. An out-of-range sel never grants.
//   mode = 1 : round-robin. The search for a valid channel starts at rr_ptr
//              and wraps modulo CHANNELS.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    CHANNELS*WIDTH packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept (one-hot or zero, all-zero in reset)
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index for fixed mode
//   out_data   registered selected data
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accept
//   out_chan   index of the channel that supplied out_data
module chan_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic [WIDTH-1:0]    out_data_r;
    logic                out_valid_r;
    logic [SEL_W-1:0]    out_chan_r;
    logic [SEL_W-1:0]    rr_ptr_r;

    logic                load_en_s;
    logic                grant_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic                transfer_s;
    logic [SEL_W:0]      rr_sum_s;
    logic [SEL_W-1:0]    rr_idx_s;
    logic [CHANNELS-1:0] in_ready_s;
    logic [SEL_W-1:0]    rr_next_s;

    // The output register can take a new word when empty or being drained now.
    assign load_en_s  = !out_valid_r || out_ready;
    assign transfer_s = grant_s && load_en_s;

    // Grant selection: fixed index or round-robin search from rr_ptr.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = '0;
        rr_sum_s    = '0;
        rr_idx_s    = '0;
        if (mode == 1'b0) begin
            if ({1'b0, sel} < (SEL_W+1)'(CHANNELS)) begin
                if (in_valid[sel]) begin
                    grant_s     = 1'b1;
                    grant_idx_s = sel;
                end else begin
                    grant_s     = 1'b0;
                end
            end else begin
                grant_s = 1'b0;
            end
        end else begin
            // Walk offsets from farthest to nearest so the nearest valid
            // channel (in search order from rr_ptr) is the one that sticks.
            for (int off = CHANNELS - 1; off >= 0; off--) begin
                rr_sum_s = {1'b0, rr_ptr_r} + (SEL_W+1)'(off);
                if (rr_sum_s >= (SEL_W+1)'(CHANNELS)) begin
                    rr_sum_s = rr_sum_s - (SEL_W+1)'(CHANNELS);
                end else begin
                    rr_sum_s = rr_sum_s;
                end
                rr_idx_s = rr_sum_s[SEL_W-1:0];
                if (in_valid[rr_idx_s]) begin
                    grant_s     = 1'b1;
                    grant_idx_s = rr_idx_s;
                end else begin
                    grant_s     = grant_s;
                end
            end
        end
    end

    // Per-channel accept: one-hot on the granted channel, quiet during reset.
    always_comb begin
        in_ready_s = '0;
        if (rst_n && transfer_s) begin
            in_ready_s[grant_idx_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    // Pointer advances past the granted channel, wrapping at the top.
    always_comb begin
        rr_next_s = '0;
        if (grant_idx_s == SEL_W'(CHANNELS - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_idx_s + SEL_W'(1);
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_chan_r  <= '0;
            rr_ptr_r    <= '0;
        end else begin
            if (transfer_s) begin
                out_data_r  <= in_data[grant_idx_s*WIDTH +: WIDTH];
                out_chan_r  <= grant_idx_s;
                out_valid_r <= 1'b1;
                if (mode) begin
                    rr_ptr_r <= rr_next_s;
                end else begin
                    rr_ptr_r <= rr_ptr_r;
                end
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_chan  = out_chan_r;

endmodule
